ad56x3_rx: RTL and testbench

- Serial-side receiver for the AD56x3 three-wire DAC interface (SYNC/SCLK/DIN, 24-bit frames).
- Sits on the far end of the DAC driver's serial output. Used as an on-chip DAC emulator and as a loopback checker in the fpga-drivers designs.
- Oversamples the serial lines on the system clock and decodes command, address and data.
- Maintains emulated input and DAC registers per channel and reports every completed frame.

---
 rtl/ad56x3_rx.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ad56x3_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ad56x3_rx.sv
// AD56x3 three-wire serial receiver: decodes 24-bit SYNC/SCLK/DIN frames
// into emulated DAC state. Optional timing checker: AD56X3_RX_TIMING_CHECK_EN.
module ad56x3_rx #(
    parameter string SIGN_A     = "UNSIGNED",
    parameter string SIGN_B     = "SIGNED",
    parameter int    DATA_WIDTH = 14,
    parameter int    SYNC_MIN   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dacSync,
    input  logic                  dacSclk,
    input  logic                  dacDin,
    input  logic                  errClr,
    output logic                  frmValid,
    output logic [2:0]            frmCmd,
    output logic [2:0]            frmAdr,
    output logic [15:0]           frmData,
    output logic [DATA_WIDTH-1:0] dacA,
    output logic [DATA_WIDTH-1:0] dacB,
    output logic                  updA,
    output logic                  updB,
    output logic [3:0]            pwrDn,
    output logic                  refOn,
    output logic                  errAbort,
    output logic                  errTiming
);

    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] XOR_A = (SIGN_A == "SIGNED") ? MSB : '0;
    localparam logic [DW-1:0] XOR_B = (SIGN_B == "SIGNED") ? MSB : '0;

    if (DATA_WIDTH != 12 && DATA_WIDTH != 14 && DATA_WIDTH != 16) begin : g_bad_dw
        $error("ad56x3_rx: DATA_WIDTH must be 12, 14 or 16");
    end
    if (SYNC_MIN < 1 || SYNC_MIN > 255) begin : g_bad_smin
        $error("ad56x3_rx: SYNC_MIN must be 1..255");
    end

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      meta_q, syn_q;
    logic            sclk_prev_q;
    logic [20:0]     sh_q, sh_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            frm_valid_q, frm_valid_d;
    logic [2:0]      frm_cmd_q, frm_cmd_d;
    logic [2:0]      frm_adr_q, frm_adr_d;
    logic [15:0]     frm_data_q, frm_data_d;
    logic [DW-1:0]   in_a_q, in_a_d, in_b_q, in_b_d;
    logic [DW-1:0]   dac_a_q, dac_a_d, dac_b_q, dac_b_d;
    logic            upd_a_q, upd_a_d, upd_b_q, upd_b_d;
    logic [3:0]      pwr_q, pwr_d;
    logic            ref_q, ref_d;
    logic            err_abort_q, err_abort_d;

    logic            sync_s, sclk_s, din_s, sclk_fall;
    logic            abort_set, decode, sel_a, sel_b;
    logic [21:0]     word;
    logic [2:0]      cmd, adr;
    logic [15:0]     data;
    logic [DW-1:0]   code;

    assign sync_s    = syn_q[2];
    assign sclk_s    = syn_q[1];
    assign din_s     = syn_q[0];
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        frm_valid_d = 1'b0;
        frm_cmd_d   = frm_cmd_q;
        frm_adr_d   = frm_adr_q;
        frm_data_d  = frm_data_q;
        in_a_d      = in_a_q;
        in_b_d      = in_b_q;
        dac_a_d     = dac_a_q;
        dac_b_d     = dac_b_q;
        upd_a_d     = 1'b0;
        upd_b_d     = 1'b0;
        pwr_d       = pwr_q;
        ref_d       = ref_q;
        abort_set   = 1'b0;
        decode      = 1'b0;
        word        = {sh_q, din_s};
        cmd         = word[21:19];
        adr         = word[18:16];
        data        = word[15:0];
        code        = data[15 -: DATA_WIDTH];
        sel_a       = (adr == 3'b000) || (adr == 3'b111);
        sel_b       = (adr == 3'b001) || (adr == 3'b111);

        unique case (state_q)
            S_WAIT: begin
                if (sync_s) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!sync_s) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (sync_s) begin
                    abort_set = 1'b1;
                    state_d   = S_IDLE;
                end else if (sclk_fall) begin
                    sh_d  = {sh_q[19:0], din_s};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        decode  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase

        // The last bit is decoded straight from the synchroniser output.
        if (decode) begin
            frm_valid_d = 1'b1;
            frm_cmd_d   = cmd;
            frm_adr_d   = adr;
            frm_data_d  = data;
            if (sel_a || sel_b) begin
                unique case (cmd)
                    3'b000: begin
                        if (sel_a) in_a_d = code;
                        if (sel_b) in_b_d = code;
                    end
                    3'b001: begin
                        if (sel_a) begin
                            dac_a_d = in_a_q ^ XOR_A;
                            upd_a_d = 1'b1;
                        end
                        if (sel_b) begin
                            dac_b_d = in_b_q ^ XOR_B;
                            upd_b_d = 1'b1;
                        end
                    end
                    3'b010: begin
                        if (sel_a) in_a_d = code;
                        if (sel_b) in_b_d = code;
                        dac_a_d = (sel_a ? code : in_a_q) ^ XOR_A;
                        dac_b_d = (sel_b ? code : in_b_q) ^ XOR_B;
                        upd_a_d = 1'b1;
                        upd_b_d = 1'b1;
                    end
                    3'b011: begin
                        if (sel_a) begin
                            in_a_d  = code;
                            dac_a_d = code ^ XOR_A;
                            upd_a_d = 1'b1;
                        end
                        if (sel_b) begin
                            in_b_d  = code;
                            dac_b_d = code ^ XOR_B;
                            upd_b_d = 1'b1;
                        end
                    end
                    3'b100: begin
                        if (sel_b) pwr_d[3:2] = data[5:4];
                        if (sel_a) pwr_d[1:0] = data[5:4];
                    end
                    3'b101: begin
                        // Clear returns the channels to their reset state.
                        in_a_d  = '0;
                        in_b_d  = '0;
                        dac_a_d = '0;
                        dac_b_d = '0;
                        upd_a_d = 1'b1;
                        upd_b_d = 1'b1;
                        if (data[0]) begin
                            pwr_d = '0;
                            ref_d = 1'b0;
                        end
                    end
                    3'b110: ;
                    3'b111: ref_d = data[0];
                endcase
            end
        end

        err_abort_d = abort_set | (err_abort_q & ~errClr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_WAIT;
            meta_q      <= '0;
            syn_q       <= '0;
            sclk_prev_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            frm_valid_q <= 1'b0;
            frm_cmd_q   <= '0;
            frm_adr_q   <= '0;
            frm_data_q  <= '0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            dac_a_q     <= '0;
            dac_b_q     <= '0;
            upd_a_q     <= 1'b0;
            upd_b_q     <= 1'b0;
            pwr_q       <= '0;
            ref_q       <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            meta_q      <= {dacSync, dacSclk, dacDin};
            syn_q       <= meta_q;
            sclk_prev_q <= sclk_s;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            frm_valid_q <= frm_valid_d;
            frm_cmd_q   <= frm_cmd_d;
            frm_adr_q   <= frm_adr_d;
            frm_data_q  <= frm_data_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            dac_a_q     <= dac_a_d;
            dac_b_q     <= dac_b_d;
            upd_a_q     <= upd_a_d;
            upd_b_q     <= upd_b_d;
            pwr_q       <= pwr_d;
            ref_q       <= ref_d;
            err_abort_q <= err_abort_d;
        end
    end

`ifdef AD56X3_RX_TIMING_CHECK_EN
    localparam logic [7:0] SYNC_MIN_C = 8'(SYNC_MIN);

    logic [7:0] hi_q, hi_d;
    logic [1:0] ph_q, ph_d;
    logic       err_tim_q, err_tim_d;
    logic       tim_set, sclk_chg;

    assign sclk_chg = sclk_s ^ sclk_prev_q;

    always_comb begin
        hi_d    = hi_q;
        ph_d    = ph_q;
        tim_set = 1'b0;
        if (state_q != S_IDLE) hi_d = '0;
        else if (hi_q != 8'hFF) hi_d = hi_q + 8'd1;
        // ph_q holds how many cycles the current SCLK level has lasted.
        if (sclk_chg) ph_d = 2'd1;
        else if (ph_q != 2'd3) ph_d = ph_q + 2'd1;
        if (state_q == S_SHIFT && sclk_chg && ph_q < 2'd2) tim_set = 1'b1;
        if (state_q == S_IDLE && !sync_s && hi_q < SYNC_MIN_C) tim_set = 1'b1;
        err_tim_d = tim_set | (err_tim_q & ~errClr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            ph_q      <= 2'd3;
            err_tim_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            ph_q      <= ph_d;
            err_tim_q <= err_tim_d;
        end
    end

    assign errTiming = err_tim_q;
`else
    assign errTiming = 1'b0;
`endif

    assign frmValid = frm_valid_q;
    assign frmCmd   = frm_cmd_q;
    assign frmAdr   = frm_adr_q;
    assign frmData  = frm_data_q;
    assign dacA     = dac_a_q;
    assign dacB     = dac_b_q;
    assign updA     = upd_a_q;
    assign updB     = upd_b_q;
    assign pwrDn    = pwr_q;
    assign refOn    = ref_q;
    assign errAbort = err_abort_q;

endmodule

// File: tb/tb_ad56x3_rx.sv
// Directed bench for ad56x3_rx: a frame table plus abort, reset and
// SYNC-gap sequences, driving the raw serial lines like the DAC driver.
module tb_ad56x3_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dacSync = 1'b1;
    logic        dacSclk = 1'b1;
    logic        dacDin = 1'b0;
    logic        errClr = 1'b0;
    logic        frmValid;
    logic [2:0]  frmCmd, frmAdr;
    logic [15:0] frmData;
    logic [13:0] dacA, dacB;
    logic        updA, updB;
    logic [3:0]  pwrDn;
    logic        refOn, errAbort, errTiming;

    int total = 0;
    int bad = 0;
    int nval = 0;
    int nupa = 0;
    int nupb = 0;

    ad56x3_rx dut (
        .clk(clk), .reset(reset),
        .dacSync(dacSync), .dacSclk(dacSclk), .dacDin(dacDin),
        .errClr(errClr),
        .frmValid(frmValid), .frmCmd(frmCmd), .frmAdr(frmAdr),
        .frmData(frmData), .dacA(dacA), .dacB(dacB),
        .updA(updA), .updB(updB), .pwrDn(pwrDn), .refOn(refOn),
        .errAbort(errAbort), .errTiming(errTiming)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frmValid) nval <= nval + 1;
        if (updA) nupa <= nupa + 1;
        if (updB) nupb <= nupb + 1;
    end

    typedef struct {
        logic [23:0] w;
        logic [13:0] da;
        logic [13:0] db;
        int          ua;
        int          ub;
        logic [3:0]  pd;
        logic        rf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic frame_start();
        dacSync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int from,
                             input int to);
        for (int i = from; i < to; i++) begin
            dacDin = w[23-i];
            repeat (3) @(negedge clk);
            dacSclk = 1'b0;
            repeat (3) @(negedge clk);
            dacSclk = 1'b1;
        end
    endtask

    task automatic frame_end(input int gap);
        repeat (3) @(negedge clk);
        dacSync = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [23:0] w, input int gap);
        frame_start();
        send_bits(w, 0, 24);
        frame_end(gap);
    endtask

    initial begin
        int v0, a0, b0;
        vecs[0]  = '{24'h181234, 14'h048D, 14'h0000, 1, 0, 4'h0, 1'b0};
        vecs[1]  = '{24'h01FFFC, 14'h048D, 14'h0000, 0, 0, 4'h0, 1'b0};
        vecs[2]  = '{24'h09ABCD, 14'h048D, 14'h1FFF, 0, 1, 4'h0, 1'b0};
        vecs[3]  = '{24'h1F8000, 14'h2000, 14'h0000, 1, 1, 4'h0, 1'b0};
        vecs[4]  = '{24'h380011, 14'h2000, 14'h0000, 0, 0, 4'h0, 1'b1};
        vecs[5]  = '{24'h210030, 14'h2000, 14'h0000, 0, 0, 4'hC, 1'b1};
        vecs[6]  = '{24'h200010, 14'h2000, 14'h0000, 0, 0, 4'hD, 1'b1};
        vecs[7]  = '{24'h1A5555, 14'h2000, 14'h0000, 0, 0, 4'hD, 1'b1};
        vecs[8]  = '{24'h280001, 14'h0000, 14'h0000, -1, -1, 4'h0, 1'b0};
        vecs[9]  = '{24'h004000, 14'h0000, 14'h0000, 0, 0, 4'h0, 1'b0};
        vecs[10] = '{24'h11C000, 14'h1000, 14'h1000, 1, 1, 4'h0, 1'b0};
        vecs[11] = '{24'h300000, 14'h1000, 14'h1000, 0, 0, 4'h0, 1'b0};
        vecs[12] = '{24'h0F0000, 14'h1000, 14'h1000, 1, 1, 4'h0, 1'b0};

        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(frmValid), 0);
        chk("rst_data", 32'(frmData), 0);
        chk("rst_dacA", 32'(dacA), 0);
        chk("rst_dacB", 32'(dacB), 0);
        chk("rst_pwr", 32'(pwrDn), 0);
        chk("rst_err", 32'({errAbort, errTiming, refOn}), 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            v0 = nval; a0 = nupa; b0 = nupb;
            send_frame(vecs[i].w, 10);
            chk($sformatf("v%0d_valid", i), nval - v0, 1);
            chk($sformatf("v%0d_cmd", i), 32'(frmCmd), 32'(vecs[i].w[21:19]));
            chk($sformatf("v%0d_adr", i), 32'(frmAdr), 32'(vecs[i].w[18:16]));
            chk($sformatf("v%0d_data", i), 32'(frmData), 32'(vecs[i].w[15:0]));
            chk($sformatf("v%0d_dacA", i), 32'(dacA), 32'(vecs[i].da));
            chk($sformatf("v%0d_dacB", i), 32'(dacB), 32'(vecs[i].db));
            if (vecs[i].ua >= 0) chk($sformatf("v%0d_updA", i), nupa - a0, vecs[i].ua);
            if (vecs[i].ub >= 0) chk($sformatf("v%0d_updB", i), nupb - b0, vecs[i].ub);
            chk($sformatf("v%0d_pwr", i), 32'(pwrDn), 32'(vecs[i].pd));
            chk($sformatf("v%0d_ref", i), 32'(refOn), 32'(vecs[i].rf));
        end

        // SYNC raised after 10 bits
        v0 = nval;
        frame_start();
        send_bits(24'h18FFFF, 0, 10);
        frame_end(10);
        chk("abort_novalid", nval - v0, 0);
        chk("abort_flag", 32'(errAbort), 1);
        chk("abort_dacA", 32'(dacA), 32'h1000);
        send_frame(24'h180400, 10);
        chk("post_abort_valid", nval - v0, 1);
        chk("post_abort_dacA", 32'(dacA), 32'h0100);
        chk("abort_sticky", 32'(errAbort), 1);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        @(negedge clk);
        chk("abort_clr", 32'(errAbort), 0);

        // reset mid-frame, released with SYNC still low
        frame_start();
        send_bits(24'h18AAAA, 0, 12);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_dacA", 32'(dacA), 0);
        chk("mrst_frm", 32'({frmCmd, frmAdr, frmData}), 0);
        v0 = nval;
        send_bits(24'h18AAAA, 12, 24);
        frame_end(10);
        chk("mrst_ignored", nval - v0, 0);
        chk("mrst_dacA2", 32'(dacA), 0);
        send_frame(24'h180800, 10);
        chk("mrst_next_valid", nval - v0, 1);
        chk("mrst_next_dacA", 32'(dacA), 32'h0200);
        chk("tim_before", 32'(errTiming), 0);

        // short SYNC-high gap between two frames
        v0 = nval;
        send_frame(24'h180C00, 3);
        send_frame(24'h181000, 10);
        chk("gap_valid", nval - v0, 2);
        chk("gap_dacA", 32'(dacA), 32'h0400);
`ifdef AD56X3_RX_TIMING_CHECK_EN
        chk("gap_errTiming", 32'(errTiming), 1);
`else
        chk("gap_errTiming", 32'(errTiming), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
